mic_mem_responder: RTL

// Memory-side responder for the MIC datapath byte memory port. Accepts wr/rd/fetch

---
 rtl/mic_mem_responder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mic_mem_responder.sv
// mic_mem_responder: byte-memory responder for the MIC datapath.
// Accepts one write/read/fetch command at a time and answers after LATENCY edges.
// Optional feature macro: MIC_MEM_STATS_EN adds saturating per-command response counters.
module mic_mem_responder #(
  parameter int NBITS      = 32,
  parameter int WORD       = 8,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NBITS-1:0] mem_addr,
  input  logic [WORD-1:0]  mem_wdata,
  input  logic             write_enb,
  input  logic             rd,
  input  logic             fetch,
  output logic [WORD-1:0]  mem_rdata,
  output logic             rd_valid,
  output logic             fetch_valid,
  output logic             wr_done,
  output logic             busy,
  output logic             addr_err,
  output logic             cmd_conflict
`ifdef MIC_MEM_STATS_EN
  ,
  output logic [15:0]      rd_count,
  output logic [15:0]      wr_count,
  output logic [15:0]      fetch_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // BUSY counts down from here; LATENCY=1 skips BUSY entirely.
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;
  typedef enum logic [1:0] {C_WR, C_RD, C_FETCH} cmd_t;

  state_t                state_q, state_d;
  cmd_t                  cmd_q, cmd_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [WORD-1:0]       wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic                  conflict_q, conflict_d;
  logic [WORD-1:0]       rdata_q, rdata_d;

  logic [WORD-1:0]       mem [DEPTH];

  logic                  any_cmd;
  logic                  multi_cmd;
  logic                  in_range;
  logic                  enter_resp;
  logic                  mem_we;

  // Next-state, command capture, and response data selection.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    conflict_d = 1'b0;
    rdata_d    = '0;
    enter_resp = 1'b0;
    mem_we     = 1'b0;

    any_cmd    = write_enb | rd | fetch;
    multi_cmd  = (write_enb & rd) | (write_enb & fetch) | (rd & fetch);
    in_range   = ((mem_addr >> DEPTH_LOG2) == '0);

    case (state_q)
      S_IDLE, S_RESP: begin
        if (any_cmd) begin
          // Priority write > read > fetch; lower-priority commands are dropped.
          cmd_d      = write_enb ? C_WR : (rd ? C_RD : C_FETCH);
          idx_d      = mem_addr[DEPTH_LOG2-1:0];
          wdata_d    = mem_wdata;
          err_d      = ~in_range;
          conflict_d = multi_cmd;
          cnt_d      = CNT_LOAD;
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_BUSY;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Commit and sample on the edge entering RESP, using the captured command
    // (the _d copies equal the _q copies except when LATENCY=1 accepts directly).
    if (enter_resp && !err_d) begin
      if (cmd_d == C_WR) begin
        mem_we = ~reset;
      end else begin
        rdata_d = mem[idx_d];
      end
    end
  end

  // Control state and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 4'd0;
      conflict_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      conflict_q <= conflict_d;
      rdata_q    <= rdata_d;
    end
  end

  // Captured transaction fields; only meaningful while busy, so not reset.
  always_ff @(posedge clk) begin
    cmd_q   <= cmd_d;
    idx_q   <= idx_d;
    wdata_q <= wdata_d;
    err_q   <= err_d;
  end

  // Byte storage; deliberately survives reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_d] <= wdata_d;
    end
  end

  assign mem_rdata    = rdata_q;
  assign busy         = (state_q != S_IDLE);
  assign rd_valid     = (state_q == S_RESP) && (cmd_q == C_RD);
  assign fetch_valid  = (state_q == S_RESP) && (cmd_q == C_FETCH);
  assign wr_done      = (state_q == S_RESP) && (cmd_q == C_WR);
  assign addr_err     = (state_q == S_RESP) && err_q;
  assign cmd_conflict = conflict_q;

`ifdef MIC_MEM_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count responses (including out-of-range ones) so the value is visible in RESP.
  always_comb begin
    rd_count_d    = rd_count_q;
    wr_count_d    = wr_count_q;
    fetch_count_d = fetch_count_q;
    if (enter_resp) begin
      case (cmd_d)
        C_WR:    wr_count_d    = sat_inc(wr_count_q);
        C_RD:    rd_count_d    = sat_inc(rd_count_q);
        default: fetch_count_d = sat_inc(fetch_count_q);
      endcase
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count_q    <= 16'd0;
      wr_count_q    <= 16'd0;
      fetch_count_q <= 16'd0;
    end else begin
      rd_count_q    <= rd_count_d;
      wr_count_q    <= wr_count_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign rd_count    = rd_count_q;
  assign wr_count    = wr_count_q;
  assign fetch_count = fetch_count_q;
`endif

endmodule
